font_fetch_arb: RTL and testbench

FONT_FETCH_ARB -- requirements
Module: font_fetch_arb

---
 rtl/font_fetch_arb.sv | 142 ++++++++++++++
 tb/tb_font_fetch_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/font_fetch_arb.sv
// Font memory fetch arbiter. The display and a host share one single-port
// font memory. The display normally wins every cycle, and a starvation
// counter forces the host in when it has waited long enough.
// A two-stage tag pipeline sends each returned row back to the requester
// that owns it.
//
// Host FSM states
//   state  | meaning
//   H_IDLE | no host fetch in flight; host may be granted
//   H_WAIT | host address issued; memory is reading it
//   H_ACK  | host row is on mem_data_i; captured at the next edge
module font_fetch_arb #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  disp_req_i,
    input  logic [6:0]            disp_char_i,
    input  logic [3:0]            disp_row_i,
    output logic                  disp_valid_o,
    output logic [DATA_WIDTH-1:0] disp_data_o,
    output logic                  disp_drop_o,
    input  logic                  host_req_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    output logic                  host_ack_o,
    output logic [DATA_WIDTH-1:0] host_data_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {H_IDLE, H_WAIT, H_ACK} host_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_t;

    localparam int         CNT_W     = 4;
    localparam [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    host_state_t           host_state;
    host_state_t           host_next;
    tag_t                  tag_s1;
    tag_t                  tag_s2;
    tag_t                  tag_next;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      starve_next;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic                  host_elig;
    logic                  starve_hit;
    logic                  grant_host;
    logic                  grant_disp;
    logic                  drop_now;

    assign disp_addr = ADDR_WIDTH'({disp_char_i, disp_row_i});

    // Arbitration: the display wins unless the host has hit the starvation limit.
    always_comb begin
        host_elig  = (host_state == H_IDLE) && host_req_i;
        starve_hit = (starve_cnt == LIMIT_CNT);
        grant_host = host_elig && (!disp_req_i || starve_hit);
        grant_disp = disp_req_i && !grant_host;
        drop_now   = disp_req_i && grant_host;
        tag_next   = TAG_NONE;
        if (grant_host) begin
            tag_next = TAG_HOST;
        end else if (grant_disp) begin
            tag_next = TAG_DISP;
        end
    end

    // Starvation counter: counts eligible-but-denied edges, saturating at the limit.
    always_comb begin
        starve_next = starve_cnt;
        if (!host_elig || grant_host) begin
            starve_next = '0;
        end else if (!starve_hit) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // Host FSM next state. H_ACK is held during the cycle the data sits on
    // mem_data_i, so H_IDLE is reached in the ack cycle. A host still
    // requesting can then be re-granted at the edge that ends the ack cycle.
    always_comb begin
        host_next = host_state;
        case (host_state)
            H_IDLE:  if (grant_host) host_next = H_WAIT;
            H_WAIT:  if (tag_s1 == TAG_HOST) host_next = H_ACK;
            H_ACK:   host_next = H_IDLE;
            default: host_next = H_IDLE;
        endcase
    end

    // Host FSM and starvation counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            host_state <= H_IDLE;
            starve_cnt <= '0;
        end else begin
            host_state <= host_next;
            starve_cnt <= starve_next;
        end
    end

    // Address register and owner tag pipeline, aligned with mem_data_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_addr_o  <= '0;
            tag_s1      <= TAG_NONE;
            tag_s2      <= TAG_NONE;
            disp_drop_o <= 1'b0;
        end else begin
            if (grant_host) begin
                mem_addr_o <= host_addr_i;
            end else if (grant_disp) begin
                mem_addr_o <= disp_addr;
            end
            tag_s1      <= tag_next;
            tag_s2      <= tag_s1;
            disp_drop_o <= drop_now;
        end
    end

    // Return path: register memory data into the owner's output; hold otherwise.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            disp_valid_o <= 1'b0;
            disp_data_o  <= '0;
            host_ack_o   <= 1'b0;
            host_data_o  <= '0;
        end else begin
            disp_valid_o <= (tag_s2 == TAG_DISP);
            host_ack_o   <= (tag_s2 == TAG_HOST);
            if (tag_s2 == TAG_DISP) begin
                disp_data_o <= mem_data_i;
            end
            if (tag_s2 == TAG_HOST) begin
                host_data_o <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_font_fetch_arb.sv
// Directed bench for font_fetch_arb with a synchronous font memory model.
module tb_font_fetch_arb;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        disp_req_i;
    logic [6:0]  disp_char_i;
    logic [3:0]  disp_row_i;
    logic        disp_valid_o;
    logic [7:0]  disp_data_o;
    logic        disp_drop_o;
    logic        host_req_i;
    logic [10:0] host_addr_i;
    logic        host_ack_o;
    logic [7:0]  host_data_o;
    logic [10:0] mem_addr_o;
    logic [7:0]  mem_data_i;

    int n_total = 0;
    int n_bad   = 0;

    logic [10:0] seq_addr [16];

    font_fetch_arb #(
        .ADDR_WIDTH  (11),
        .DATA_WIDTH  (8),
        .STARVE_LIMIT(8)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .disp_req_i  (disp_req_i),
        .disp_char_i (disp_char_i),
        .disp_row_i  (disp_row_i),
        .disp_valid_o(disp_valid_o),
        .disp_data_o (disp_data_o),
        .disp_drop_o (disp_drop_o),
        .host_req_i  (host_req_i),
        .host_addr_i (host_addr_i),
        .host_ack_o  (host_ack_o),
        .host_data_o (host_data_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i)
    );

    // 25 MHz pixel clock.
    always #20 clk_i = ~clk_i;

    // Font memory contents: low address byte xor the top three address bits.
    function automatic logic [7:0] memf(input logic [10:0] a);
        return a[7:0] ^ {5'b0, a[10:8]};
    endfunction

    // Synchronous memory: data one cycle after the address.
    always @(posedge clk_i) mem_data_i <= memf(mem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i      = 1'b0;
        disp_req_i  = 1'b1;
        disp_char_i = 7'h41;
        disp_row_i  = 4'h3;
        host_req_i  = 1'b0;
        host_addr_i = '0;
        mem_data_i  = '0;

        // Reset state, with a display request pending that must not be granted.
        repeat (3) step();
        chk("rst_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_dvalid", 32'(disp_valid_o), 32'h0);
        chk("rst_ddata", 32'(disp_data_o), 32'h0);
        chk("rst_drop", 32'(disp_drop_o), 32'h0);
        chk("rst_ack", 32'(host_ack_o), 32'h0);
        chk("rst_hdata", 32'(host_data_o), 32'h0);
        chk("rst_cnt", 32'(dut.starve_cnt), 32'h0);
        chk("rst_fsm", 32'(dut.host_state), 32'h0);

        // Display fetch of 0x413 granted at the first edge after release.
        rstn_i = 1'b1;
        step();
        chk("d_addr", 32'(mem_addr_o), 32'h413);
        chk("d_valid_k", 32'(disp_valid_o), 32'h0);
        disp_req_i = 1'b0;
        step();
        chk("d_valid_k1", 32'(disp_valid_o), 32'h0);
        step();
        chk("d_valid_k2", 32'(disp_valid_o), 32'h1);
        chk("d_data_k2", 32'(disp_data_o), 32'h17);
        step();
        chk("d_valid_k3", 32'(disp_valid_o), 32'h0);
        chk("d_data_hold", 32'(disp_data_o), 32'h17);
        chk("addr_hold", 32'(mem_addr_o), 32'h413);

        // Host read of 0x7FF held through the ack, then re-granted for 0x123.
        host_req_i  = 1'b1;
        host_addr_i = 11'h7FF;
        step();
        chk("h_addr", 32'(mem_addr_o), 32'h7FF);
        chk("h_ack_k", 32'(host_ack_o), 32'h0);
        step();
        chk("h_ack_k1", 32'(host_ack_o), 32'h0);
        step();
        chk("h_ack_k2", 32'(host_ack_o), 32'h1);
        chk("h_data_k2", 32'(host_data_o), 32'hF8);
        host_addr_i = 11'h123;
        step();
        chk("h_ack_k3", 32'(host_ack_o), 32'h0);
        chk("h_regrant_addr", 32'(mem_addr_o), 32'h123);
        chk("h_data_hold", 32'(host_data_o), 32'hF8);
        host_req_i = 1'b0;
        step();
        chk("h2_ack_k1", 32'(host_ack_o), 32'h0);
        step();
        chk("h2_ack_k2", 32'(host_ack_o), 32'h1);
        chk("h2_data", 32'(host_data_o), 32'h22);
        step();
        chk("h2_ack_off", 32'(host_ack_o), 32'h0);

        // Sixteen back-to-back display requests.
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                disp_req_i  = 1'b1;
                disp_char_i = 7'(8'h20 + c);
                disp_row_i  = 4'(c);
                seq_addr[c] = {disp_char_i, disp_row_i};
            end else begin
                disp_req_i = 1'b0;
            end
            step();
            if (c >= 2) begin
                chk($sformatf("seq_valid%0d", c - 2), 32'(disp_valid_o), 32'h1);
                chk($sformatf("seq_data%0d", c - 2), 32'(disp_data_o), 32'(memf(seq_addr[c - 2])));
            end
        end
        step();
        chk("seq_end", 32'(disp_valid_o), 32'h0);

        // Continuous display plus host: host denied 8 times, forced in on the 9th edge.
        disp_req_i  = 1'b1;
        disp_char_i = 7'h10;
        disp_row_i  = 4'h0;
        host_req_i  = 1'b1;
        host_addr_i = 11'h055;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("sv_cnt%0d", e), 32'(dut.starve_cnt), (e <= 8) ? 32'(e) : 32'h0);
            chk($sformatf("sv_addr%0d", e), 32'(mem_addr_o), (e == 9) ? 32'h055 : 32'h100);
            chk($sformatf("sv_drop%0d", e), 32'(disp_drop_o), (e == 9) ? 32'h1 : 32'h0);
            chk($sformatf("sv_ack%0d", e), 32'(host_ack_o), (e == 11) ? 32'h1 : 32'h0);
            chk($sformatf("sv_dvalid%0d", e), 32'(disp_valid_o), (e >= 3 && e != 11) ? 32'h1 : 32'h0);
            if (e == 11) begin
                chk("sv_hdata", 32'(host_data_o), 32'h55);
                host_req_i = 1'b0;
            end
        end
        disp_req_i = 1'b0;
        repeat (3) step();

        // Reset one cycle after a host grant: in-flight fetch is discarded.
        host_req_i  = 1'b1;
        host_addr_i = 11'h2AA;
        step();
        chk("r_grant_addr", 32'(mem_addr_o), 32'h2AA);
        step();
        rstn_i = 1'b0;
        #1;
        chk("r_addr", 32'(mem_addr_o), 32'h0);
        chk("r_hdata", 32'(host_data_o), 32'h0);
        chk("r_ddata", 32'(disp_data_o), 32'h0);
        chk("r_ack", 32'(host_ack_o), 32'h0);
        chk("r_fsm", 32'(dut.host_state), 32'h0);
        host_req_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("r_noack%0d", i), 32'(host_ack_o), 32'h0);
        end
        host_req_i = 1'b1;
        step();
        chk("r_new_addr", 32'(mem_addr_o), 32'h2AA);
        step();
        chk("r_new_ack_k1", 32'(host_ack_o), 32'h0);
        step();
        chk("r_new_ack", 32'(host_ack_o), 32'h1);
        chk("r_new_data", 32'(host_data_o), 32'hA8);
        host_req_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
